// File: rtl/fifo_w16_r32_4k.sv
// Single-clock FIFO: 16-bit write side, 32-bit read side, 4096 half-words deep.
// The first half-word of each pair lands in rd_data[15:0] and the second in rd_data[31:16].
module fifo_w16_r32_4k #(
  parameter int unsigned WR_DEPTH_WIDTH   = 12,
  parameter int unsigned WR_DATA_WIDTH    = 16,
  parameter int unsigned RD_DEPTH_WIDTH   = 11,
  parameter int unsigned RD_DATA_WIDTH    = 32,
  parameter int unsigned ALMOST_FULL_NUM  = 1020,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WR_DATA_WIDTH-1:0]   wr_data,
  input  logic                       wr_en,
  output logic                       wr_full,
  output logic [WR_DEPTH_WIDTH:0]    wr_water_level,
  output logic                       almost_full,
  output logic [RD_DATA_WIDTH-1:0]   rd_data,
  input  logic                       rd_en,
  output logic                       rd_empty,
  output logic [RD_DEPTH_WIDTH:0]    rd_water_level,
  output logic                       almost_empty
);

  localparam int unsigned CNT_W    = WR_DEPTH_WIDTH + 1;
  localparam int unsigned RL_W     = RD_DEPTH_WIDTH + 1;
  localparam int unsigned WR_DEPTH = 1 << WR_DEPTH_WIDTH;
  localparam int unsigned RD_DEPTH = 1 << RD_DEPTH_WIDTH;

  // Two half-word banks so a full 32-bit word is read in one access.
  logic [WR_DATA_WIDTH-1:0]  mem_lo [RD_DEPTH];
  logic [WR_DATA_WIDTH-1:0]  mem_hi [RD_DEPTH];

  logic [WR_DEPTH_WIDTH-1:0] wr_ptr;
  logic [RD_DEPTH_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic                      wr_acc;
  logic                      rd_acc;

  assign wr_acc = wr_en && !rst && (cnt < CNT_W'(WR_DEPTH));
  assign rd_acc = rd_en && !rst && (cnt >= CNT_W'(2));

  always_comb begin
    cnt_nxt = cnt;
    if (wr_acc) cnt_nxt = cnt_nxt + CNT_W'(1);
    if (rd_acc) cnt_nxt = cnt_nxt - CNT_W'(2);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (wr_ptr[0]) mem_hi[wr_ptr[WR_DEPTH_WIDTH-1:1]] <= wr_data;
      else           mem_lo[wr_ptr[WR_DEPTH_WIDTH-1:1]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      rd_data <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (wr_acc) wr_ptr <= wr_ptr + WR_DEPTH_WIDTH'(1);
      if (rd_acc) begin
        rd_data <= {mem_hi[rd_ptr], mem_lo[rd_ptr]};
        rd_ptr  <= rd_ptr + RD_DEPTH_WIDTH'(1);
      end
    end
  end

  // Status decoded from the registered count; a lone odd half-word is not readable.
  assign wr_water_level = cnt;
  assign rd_water_level = cnt[CNT_W-1:1];
  assign wr_full        = (cnt == CNT_W'(WR_DEPTH));
  assign rd_empty       = (cnt < CNT_W'(2));
  assign almost_full    = (cnt >= CNT_W'(ALMOST_FULL_NUM));
  assign almost_empty   = (rd_water_level <= RL_W'(ALMOST_EMPTY_NUM));

endmodule

// File: tb/tb_fifo_w16_r32_4k.sv
// Scoreboard bench for fifo_w16_r32_4k: driver predicts read words into a queue,
// a monitor pops and compares them the cycle after each predicted read.
module tb_fifo_w16_r32_4k;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_full;
  logic [12:0] wr_water_level;
  logic        almost_full;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic [11:0] rd_water_level;
  logic        almost_empty;

  int checks = 0;
  int errors = 0;

  logic [15:0] hq[$];
  logic [31:0] exp_q[$];
  int          mcnt = 0;
  logic        rd_fire = 1'b0;
  logic        rst_mon = 1'b1;
  logic [31:0] last_word = '0;

  fifo_w16_r32_4k dut (
    .clk            (clk),
    .rst            (rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_data        (rd_data),
    .rd_en          (rd_en),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares rd_data one cycle after each predicted accepted read, else expects hold.
  always @(posedge clk) begin
    logic fire;
    logic rs;
    logic [31:0] e;
    fire = rd_fire;
    rs   = rst_mon;
    #1;
    if (rs) begin
      last_word = '0;
      chk("rd_data_reset", rd_data, 32'h0);
    end else if (fire) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: read predicted with empty queue at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        last_word = e;
        chk("rd_data", rd_data, e);
      end
    end else begin
      chk("rd_data_hold", rd_data, last_word);
    end
  end

  // One clock: drive at negedge, update model, then check status at next negedge.
  task automatic step(input logic r_st, input logic w, input logic [15:0] d, input logic r);
    logic acc_w;
    logic acc_r;
    logic [15:0] lo;
    logic [15:0] hi;
    rst     = r_st;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    rst_mon = r_st;
    rd_fire = 1'b0;
    if (r_st) begin
      hq.delete();
      mcnt = 0;
    end else begin
      acc_w = w && (mcnt < 4096);
      acc_r = r && (mcnt >= 2);
      if (acc_r) begin
        lo = hq.pop_front();
        hi = hq.pop_front();
        exp_q.push_back({hi, lo});
        rd_fire = 1'b1;
      end
      if (acc_w) hq.push_back(d);
      mcnt = mcnt + (acc_w ? 1 : 0) - (acc_r ? 2 : 0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("wr_water_level", 32'(wr_water_level), 32'(mcnt));
    chk("rd_water_level", 32'(rd_water_level), 32'(mcnt / 2));
    chk("wr_full", 32'(wr_full), 32'(mcnt == 4096));
    chk("rd_empty", 32'(rd_empty), 32'(mcnt < 2));
    chk("almost_full", 32'(almost_full), 32'(mcnt >= 1020));
    chk("almost_empty", 32'(almost_empty), 32'((mcnt / 2) <= 4));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("reset_rd_empty", 32'(rd_empty), 32'h1);
    chk("reset_wr_full", 32'(wr_full), 32'h0);
    chk("reset_almost_empty", 32'(almost_empty), 32'h1);
    chk("reset_almost_full", 32'(almost_full), 32'h0);
    chk("reset_levels", 32'({wr_water_level, rd_water_level}), 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);

    // Fill with a descending counter; the 4097th write must be dropped.
    for (int i = 0; i < 4097; i++) begin
      step(1'b0, 1'b1, 16'(32'hFFFF - i), 1'b0);
      if (i == 1018) chk("almost_full_1019", 32'(almost_full), 32'h0);
      if (i == 1019) chk("almost_full_1020", 32'(almost_full), 32'h1);
      if (i == 4095) begin
        chk("full_flag", 32'(wr_full), 32'h1);
        chk("full_wr_level", 32'(wr_water_level), 32'd4096);
        chk("full_rd_level", 32'(rd_water_level), 32'd2048);
      end
    end
    chk("overflow_level", 32'(wr_water_level), 32'd4096);

    // Drain; the 2049th read must be ignored.
    for (int k = 0; k < 2049; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      if (k == 0) chk("first_word", rd_data, 32'hFFFE_FFFF);
      if (k == 2047) chk("drained_empty", 32'(rd_empty), 32'h1);
    end
    chk("last_word_hold", rd_data, 32'hF000_F001);

    // Odd count: third half-word stays pending.
    step(1'b0, 1'b1, 16'h1111, 1'b0);
    step(1'b0, 1'b1, 16'h2222, 1'b0);
    step(1'b0, 1'b1, 16'h3333, 1'b0);
    chk("odd_rd_level", 32'(rd_water_level), 32'h1);
    chk("odd_rd_empty", 32'(rd_empty), 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("odd_word", rd_data, 32'h2222_1111);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("odd_after_empty", 32'(rd_empty), 32'h1);
    chk("odd_wr_level", 32'(wr_water_level), 32'h1);
    chk("odd_hold", rd_data, 32'h2222_1111);

    // Simultaneous read and write starting from 10 half-words.
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'(32'h0100 + i), 1'b0);
    chk("sim_start_level", 32'(wr_water_level), 32'd10);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'(32'h0200 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

    // Reset mid-fill discards contents.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 16'(32'h4000 + i), 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("midrst_level", 32'(wr_water_level), 32'h0);
    chk("midrst_empty", 32'(rd_empty), 32'h1);
    step(1'b0, 1'b1, 16'hAAAA, 1'b0);
    step(1'b0, 1'b1, 16'h5555, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("midrst_first_word", rd_data, 32'h5555_AAAA);
    step(1'b0, 1'b0, 16'h0, 1'b0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d words expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
